store_commit_sequencer: RTL and testbench

Sequences committed stores out of the store queue, one at a time, in program order. For each store at the STQ head it presents the index to the order failure detector for one check cycle, requests a pipeline flush from the oldest failing load when a violation is found, writes the store to the data cache over a valid/ready handshake, then deallocates the entry and advances the head. It sits in the LSU between the ROB commit stream, the order failure detector, the D-cache write port and the flush logic.

---
 rtl/lsu_pkg.sv | 27 ++
 rtl/circular_priority_selector.sv | 32 +++
 rtl/store_commit_sequencer.sv | 162 ++++++++++++++++
 tb/tb_store_commit_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared LSU types and sizes used by the store commit sequencer.
package lsu_pkg;

    localparam int LDQ_SIZE = 8;
    localparam int STQ_SIZE = 8;
    localparam int LW       = $clog2(LDQ_SIZE);
    localparam int SW       = $clog2(STQ_SIZE);

    typedef struct packed {
        logic        valid;
        logic [31:0] address;
        logic [31:0] data;
    } store_queue_entry;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        FLUSH = 2'd2,
        WRITE = 2'd3
    } commit_seq_state_t;

    // Next STQ slot; SW-bit arithmetic wraps STQ_SIZE-1 back to 0.
    function automatic logic [SW-1:0] stq_next(input logic [SW-1:0] idx);
        return idx + 1'b1;
    endfunction

endpackage

// File: rtl/circular_priority_selector.sv
// Finds the first set request at or after `head`, wrapping past N-1 to 0.
// Used to pick the oldest failing load relative to the LDQ head.
module circular_priority_selector #(
    parameter int N = 8
) (
    input  logic [N-1:0]         requests,
    input  logic [$clog2(N)-1:0] head,
    output logic [$clog2(N)-1:0] index,
    output logic                 found
);

    localparam int W = $clog2(N);

    logic [W-1:0] w_pos;

    // Scan from head in age order and keep the first hit.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
        index = '0;
        found = 1'b0;
        w_pos = '0;
        for (int k = 0; k < N; k++) begin
            // NOTE: blocking assignments here because each iteration must see the value written by the previous one.
            w_pos = head + W'(k);
            if (!found && requests[w_pos]) begin
                found = 1'b1;
                index = w_pos;
            end
        end
    end

endmodule

// File: rtl/store_commit_sequencer.sv
// Drains committed stores from the STQ head in program order: one check
// cycle against the order failure detector, an optional flush of the
// oldest failing load, then a D-cache write and deallocation.
module store_commit_sequencer
    import lsu_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                rob_commit_store,
    input  store_queue_entry    store_queue_entries [STQ_SIZE],
    input  logic [LW-1:0]       ldq_head,
    input  logic [LDQ_SIZE-1:0] order_failures,
    output logic [SW-1:0]       stq_head,
    output logic [SW-1:0]       stq_commit_index,
    output logic                stq_commit_valid,
    output logic                dcache_req_valid,
    input  logic                dcache_req_ready,
    output logic [31:0]         dcache_req_address,
    output logic [31:0]         dcache_req_data,
    output logic                stq_dealloc,
    output logic                flush_req,
    output logic [LW-1:0]       flush_ldq_index,
    input  logic                flush_ack
);

    commit_seq_state_t r_state;
    commit_seq_state_t w_state_next;

    logic [SW:0]      r_pending;
    logic [SW:0]      w_pending_next;
    logic [SW-1:0]    r_head;
    logic [LW-1:0]    r_flush_idx;
    logic [31:0]      r_req_address;
    logic [31:0]      r_req_data;

    logic             w_handshake;
    logic             w_load_req;
    logic             w_fail_found;
    logic [LW-1:0]    w_oldest_fail;
    store_queue_entry w_head_entry;

    assign w_head_entry = store_queue_entries[r_head];

    circular_priority_selector #(
        .N (LDQ_SIZE)
    ) u_oldest_fail (
        .requests (order_failures),
        .head     (ldq_head),
        .index    (w_oldest_fail),
        .found    (w_fail_found)
    );

    // A write retires exactly when the D-cache accepts it in WRITE.
    assign w_handshake    = (r_state == WRITE) && dcache_req_ready;
    assign w_pending_next = r_pending
                          + (SW+1)'(rob_commit_store)
                          - (SW+1)'(w_handshake);

    // Next-state selection and state-decoded outputs.
    always_comb begin
        w_state_next     = r_state;
        w_load_req       = 1'b0;
        stq_commit_valid = 1'b0;
        dcache_req_valid = 1'b0;
        stq_dealloc      = 1'b0;
        flush_req        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if ((r_pending != '0) || rob_commit_store) begin
                    w_state_next = CHECK;
                end
            end
            CHECK: begin
                stq_commit_valid = 1'b1;
                if (w_fail_found) begin
                    w_state_next = FLUSH;
                end else begin
                    w_state_next = WRITE;
                    w_load_req   = 1'b1;
                end
            end
            FLUSH: begin
                flush_req = 1'b1;
                // The store is already committed, so it is written even after a flush.
                if (flush_ack) begin
                    w_state_next = WRITE;
                    w_load_req   = 1'b1;
                end
            end
            WRITE: begin
                dcache_req_valid = 1'b1;
                if (dcache_req_ready) begin
                    stq_dealloc  = 1'b1;
                    w_state_next = (w_pending_next != '0) ? CHECK : IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Count of committed stores not yet written out.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_next;
        end
    end

    // STQ head advances on each accepted write.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_head <= '0;
        end else if (w_handshake) begin
            r_head <= stq_next(r_head);
        end
    end

    // Capture the oldest failing load during the single check cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_flush_idx <= '0;
        end else if ((r_state == CHECK) && w_fail_found) begin
            r_flush_idx <= w_oldest_fail;
        end
    end

    // Latch the head store on entry to WRITE so address/data hold under back-pressure; zero otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_req_address <= '0;
            r_req_data    <= '0;
        end else if (w_load_req) begin
            r_req_address <= w_head_entry.address;
            r_req_data    <= w_head_entry.data;
        end else if (w_handshake) begin
            r_req_address <= '0;
            r_req_data    <= '0;
        end
    end

    assign stq_head           = r_head;
    assign stq_commit_index   = r_head;
    assign flush_ldq_index    = r_flush_idx;
    assign dcache_req_address = r_req_address;
    assign dcache_req_data    = r_req_data;

    // The STQ must hold a valid entry at the head whenever a store is in flight.
    head_valid_a: assert property (@(posedge clk) disable iff (!reset_n)
                                   (r_state != IDLE) |-> w_head_entry.valid);

endmodule

// File: tb/tb_store_commit_sequencer.sv
// Self-checking bench for store_commit_sequencer: directed scenarios plus
// a randomized run scored against a transaction-level reference model.
module tb_store_commit_sequencer;
    import lsu_pkg::*;

    logic                clk = 1'b0;
    logic                reset_n;
    logic                rob_commit_store;
    store_queue_entry    stq [STQ_SIZE];
    logic [LW-1:0]       ldq_head;
    logic [LDQ_SIZE-1:0] order_failures;
    logic [SW-1:0]       stq_head;
    logic [SW-1:0]       stq_commit_index;
    logic                stq_commit_valid;
    logic                dcache_req_valid;
    logic                dcache_req_ready;
    logic [31:0]         dcache_req_address;
    logic [31:0]         dcache_req_data;
    logic                stq_dealloc;
    logic                flush_req;
    logic [LW-1:0]       flush_ldq_index;
    logic                flush_ack;

    int errors = 0;
    int checks = 0;
    int model_head = 0;

    always #5 clk = ~clk;

    store_commit_sequencer dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .rob_commit_store    (rob_commit_store),
        .store_queue_entries (stq),
        .ldq_head            (ldq_head),
        .order_failures      (order_failures),
        .stq_head            (stq_head),
        .stq_commit_index    (stq_commit_index),
        .stq_commit_valid    (stq_commit_valid),
        .dcache_req_valid    (dcache_req_valid),
        .dcache_req_ready    (dcache_req_ready),
        .dcache_req_address  (dcache_req_address),
        .dcache_req_data     (dcache_req_data),
        .stq_dealloc         (stq_dealloc),
        .flush_req           (flush_req),
        .flush_ldq_index     (flush_ldq_index),
        .flush_ack           (flush_ack)
    );

    // Oldest failing load: first set bit walking forward from the LDQ head.
    function automatic int oldest_fail(input logic [LDQ_SIZE-1:0] f, input int h);
        for (int k = 0; k < LDQ_SIZE; k++) begin
            if (f[(h + k) % LDQ_SIZE]) return (h + k) % LDQ_SIZE;
        end
        return -1;
    endfunction

    // Inputs change 1 time unit after the rising edge; outputs are read on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if ({stq_head, stq_commit_index, stq_commit_valid, dcache_req_valid, dcache_req_address, dcache_req_data, stq_dealloc, flush_req, flush_ldq_index} !== '0) begin errors++; $display("FAIL reset_outputs: got head=%h idx=%h cv=%b v=%b a=%h d=%h da=%b fr=%b fi=%h expected all zero", stq_head, stq_commit_index, stq_commit_valid, dcache_req_valid, dcache_req_address, dcache_req_data, stq_dealloc, flush_req, flush_ldq_index); end
        tick();
        reset_n = 1'b1;
        model_head = 0;
        @(negedge clk);
        checks++; if (stq_commit_valid !== 1'b0) begin errors++; $display("FAIL reset_idle: got cv=%b expected 0", stq_commit_valid); end
        tick();
    endtask

    task automatic test_single_commit();
        stq[0] = '{valid: 1'b1, address: 32'h100, data: 32'hAB};
        dcache_req_ready = 1'b1;
        rob_commit_store = 1'b1;
        @(negedge clk);
        checks++; if (stq_commit_valid !== 1'b0) begin errors++; $display("FAIL single_t0: got cv=%b expected 0", stq_commit_valid); end
        tick();
        rob_commit_store = 1'b0;
        @(negedge clk);
        checks++; if ({stq_commit_valid, stq_commit_index, dcache_req_valid} !== {1'b1, 3'd0, 1'b0}) begin errors++; $display("FAIL single_check: got cv=%b idx=%0d v=%b expected cv=1 idx=0 v=0", stq_commit_valid, stq_commit_index, dcache_req_valid); end
        tick();
        @(negedge clk);
        checks++; if ({dcache_req_valid, stq_dealloc} !== 2'b11) begin errors++; $display("FAIL single_write: got v=%b da=%b expected 1 1", dcache_req_valid, stq_dealloc); end
        checks++; if (dcache_req_address !== 32'h100 || dcache_req_data !== 32'hAB) begin errors++; $display("FAIL single_payload: got a=%h d=%h expected a=100 d=ab", dcache_req_address, dcache_req_data); end
        tick();
        model_head = 1;
        @(negedge clk);
        checks++; if (stq_head !== 3'd1) begin errors++; $display("FAIL single_head: got %0d expected 1", stq_head); end
        checks++; if ({dcache_req_valid, stq_dealloc, stq_commit_valid} !== 3'b000) begin errors++; $display("FAIL single_idle: got v=%b da=%b cv=%b expected 0 0 0", dcache_req_valid, stq_dealloc, stq_commit_valid); end
        tick();
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_a;
        logic [31:0] exp_d;
        int          n_dealloc;
        exp_a = stq[model_head].address;
        exp_d = stq[model_head].data;
        n_dealloc = 0;
        dcache_req_ready = 1'b0;
        rob_commit_store = 1'b1;
        tick();
        rob_commit_store = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) dcache_req_ready = 1'b1;
            @(negedge clk);
            if (stq_dealloc === 1'b1) n_dealloc++;
            checks++; if (dcache_req_valid !== 1'b1 || dcache_req_address !== exp_a || dcache_req_data !== exp_d) begin errors++; $display("FAIL bp_hold[%0d]: got v=%b a=%h d=%h expected v=1 a=%h d=%h", i, dcache_req_valid, dcache_req_address, dcache_req_data, exp_a, exp_d); end
            checks++; if (stq_dealloc !== (i == 3)) begin errors++; $display("FAIL bp_dealloc[%0d]: got %b expected %b", i, stq_dealloc, (i == 3)); end
            tick();
        end
        model_head = (model_head + 1) % STQ_SIZE;
        @(negedge clk);
        checks++; if (n_dealloc != 1) begin errors++; $display("FAIL bp_dealloc_count: got %0d expected 1", n_dealloc); end
        checks++; if (stq_head !== SW'(model_head) || dcache_req_valid !== 1'b0) begin errors++; $display("FAIL bp_after: got head=%0d v=%b expected head=%0d v=0", stq_head, dcache_req_valid, model_head); end
        tick();
    endtask

    task automatic test_order_failure();
        int exp_idx;
        logic [31:0] exp_a;
        exp_a = stq[model_head].address;
        dcache_req_ready = 1'b1;
        rob_commit_store = 1'b1;
        tick();
        rob_commit_store = 1'b0;
        order_failures = 8'b1000_0010;
        ldq_head = 3'd5;
        exp_idx = oldest_fail(order_failures, 5);
        @(negedge clk);
        checks++; if (stq_commit_valid !== 1'b1 || stq_commit_index !== SW'(model_head)) begin errors++; $display("FAIL of_check: got cv=%b idx=%0d expected cv=1 idx=%0d", stq_commit_valid, stq_commit_index, model_head); end
        tick();
        order_failures = 8'hFF;
        ldq_head = 3'd0;
        for (int i = 0; i < 2; i++) begin
            if (i == 1) flush_ack = 1'b1;
            @(negedge clk);
            checks++; if (flush_req !== 1'b1 || flush_ldq_index !== LW'(exp_idx) || dcache_req_valid !== 1'b0 || stq_dealloc !== 1'b0) begin errors++; $display("FAIL of_flush[%0d]: got fr=%b fi=%0d v=%b da=%b expected fr=1 fi=%0d v=0 da=0", i, flush_req, flush_ldq_index, dcache_req_valid, stq_dealloc, exp_idx); end
            tick();
        end
        flush_ack = 1'b0;
        order_failures = '0;
        @(negedge clk);
        checks++; if (flush_req !== 1'b0 || dcache_req_valid !== 1'b1 || stq_dealloc !== 1'b1 || dcache_req_address !== exp_a) begin errors++; $display("FAIL of_write: got fr=%b v=%b da=%b a=%h expected fr=0 v=1 da=1 a=%h", flush_req, dcache_req_valid, stq_dealloc, dcache_req_address, exp_a); end
        tick();
        model_head = (model_head + 1) % STQ_SIZE;
        @(negedge clk);
        checks++; if (stq_head !== SW'(model_head)) begin errors++; $display("FAIL of_head: got %0d expected %0d", stq_head, model_head); end
        tick();
    endtask

    // Retire single stores until the head reaches the requested slot.
    task automatic advance_to(input int target);
        bit seen;
        dcache_req_ready = 1'b1;
        order_failures = '0;
        while (model_head != target) begin
            seen = 1'b0;
            rob_commit_store = 1'b1;
            tick();
            rob_commit_store = 1'b0;
            for (int c = 0; c < 10 && !seen; c++) begin
                @(negedge clk);
                if (stq_dealloc === 1'b1) seen = 1'b1;
                tick();
            end
            checks++; if (!seen) begin errors++; $display("FAIL advance_timeout: got no dealloc expected one for head %0d", model_head); end
            model_head = (model_head + 1) % STQ_SIZE;
        end
    endtask

    task automatic test_burst_wrap();
        int  exp_head;
        bit  exp_cv;
        bit  exp_da;
        advance_to(6);
        exp_head = 6;
        dcache_req_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            rob_commit_store = (k < 3);
            exp_cv = (k == 1 || k == 3 || k == 5);
            exp_da = (k == 2 || k == 4 || k == 6);
            @(negedge clk);
            checks++; if ({stq_commit_valid, stq_dealloc} !== {exp_cv, exp_da} || stq_head !== SW'(exp_head)) begin errors++; $display("FAIL burst[%0d]: got cv=%b da=%b head=%0d expected cv=%b da=%b head=%0d", k, stq_commit_valid, stq_dealloc, stq_head, exp_cv, exp_da, exp_head); end
            if (exp_da) exp_head = (exp_head + 1) % STQ_SIZE;
            tick();
        end
        model_head = exp_head;
        checks++; if (stq_head !== 3'd1) begin errors++; $display("FAIL burst_final_head: got %0d expected 1", stq_head); end
    endtask

    task automatic test_commit_during_dealloc();
        int  exp_head;
        bit  exp_cv;
        bit  exp_da;
        exp_head = model_head;
        dcache_req_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            rob_commit_store = (k == 0 || k == 2);
            exp_cv = (k == 1 || k == 3);
            exp_da = (k == 2 || k == 4);
            @(negedge clk);
            checks++; if ({stq_commit_valid, stq_dealloc} !== {exp_cv, exp_da} || stq_head !== SW'(exp_head)) begin errors++; $display("FAIL cdd[%0d]: got cv=%b da=%b head=%0d expected cv=%b da=%b head=%0d", k, stq_commit_valid, stq_dealloc, stq_head, exp_cv, exp_da, exp_head); end
            if (exp_da) exp_head = (exp_head + 1) % STQ_SIZE;
            tick();
        end
        model_head = exp_head;
    endtask

    task automatic test_reset_mid_flush();
        dcache_req_ready = 1'b1;
        rob_commit_store = 1'b1;
        tick();
        rob_commit_store = 1'b0;
        order_failures = 8'h10;
        ldq_head = 3'd2;
        tick();
        order_failures = '0;
        @(negedge clk);
        checks++; if (flush_req !== 1'b1) begin errors++; $display("FAIL rmf_pre: got fr=%b expected 1", flush_req); end
        #1 reset_n = 1'b0;
        #1;
        checks++; if ({flush_req, flush_ldq_index, stq_head, dcache_req_valid, stq_commit_valid, stq_dealloc} !== '0) begin errors++; $display("FAIL rmf_async: got fr=%b fi=%0d head=%0d v=%b cv=%b da=%b expected all zero", flush_req, flush_ldq_index, stq_head, dcache_req_valid, stq_commit_valid, stq_dealloc); end
        tick();
        tick();
        reset_n = 1'b1;
        model_head = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if ({stq_commit_valid, stq_dealloc, flush_req} !== 3'b000 || stq_head !== 3'd0) begin errors++; $display("FAIL rmf_after[%0d]: got cv=%b da=%b fr=%b head=%0d expected 0 0 0 head=0", k, stq_commit_valid, stq_dealloc, flush_req, stq_head); end
            tick();
        end
    endtask

    task automatic test_random();
        int committed;
        int retired;
        int pend;
        int exp_idx;
        bit exp_flush;
        bit prev_fail;
        bit prev_ok;
        bit nxt_fail;
        bit nxt_ok;
        bit hs;
        committed = 0; retired = 0; pend = 0; exp_idx = 0;
        exp_flush = 1'b0; prev_fail = 1'b0; prev_ok = 1'b0;
        for (int i = 0; i < STQ_SIZE; i++) stq[i] = '{valid: 1'b1, address: $urandom, data: $urandom};
        for (int cyc = 0; cyc < 3000 && (committed < 60 || pend != 0); cyc++) begin
            rob_commit_store = (committed < 60) && (pend < STQ_SIZE) && ($urandom_range(0, 2) == 0);
            dcache_req_ready = (committed >= 60) || ($urandom_range(0, 3) != 0);
            flush_ack = (committed >= 60) || ($urandom_range(0, 2) == 0);
            order_failures = ($urandom_range(0, 2) == 0) ? LDQ_SIZE'($urandom) : '0;
            ldq_head = LW'($urandom);
            @(negedge clk);
            checks++; if (stq_head !== SW'(model_head)) begin errors++; $display("FAIL rnd_head cyc %0d: got %0d expected %0d", cyc, stq_head, model_head); end
            if (prev_fail) begin checks++; if (flush_req !== 1'b1) begin errors++; $display("FAIL rnd_flush_start cyc %0d: got fr=%b expected 1", cyc, flush_req); end end
            if (prev_ok) begin checks++; if (dcache_req_valid !== 1'b1) begin errors++; $display("FAIL rnd_write_start cyc %0d: got v=%b expected 1", cyc, dcache_req_valid); end end
            if (flush_req === 1'b1) begin checks++; if (!exp_flush || flush_ldq_index !== LW'(exp_idx)) begin errors++; $display("FAIL rnd_flush_idx cyc %0d: got fi=%0d armed=%b expected fi=%0d armed=1", cyc, flush_ldq_index, exp_flush, exp_idx); end end
            nxt_fail = 1'b0;
            nxt_ok = 1'b0;
            if (stq_commit_valid === 1'b1) begin
                checks++; if (stq_commit_index !== SW'(model_head) || pend == 0) begin errors++; $display("FAIL rnd_check cyc %0d: got idx=%0d pend=%0d expected idx=%0d pend>0", cyc, stq_commit_index, pend, model_head); end
                if (order_failures != '0) begin
                    nxt_fail = 1'b1;
                    exp_flush = 1'b1;
                    exp_idx = oldest_fail(order_failures, int'(ldq_head));
                end else begin
                    nxt_ok = 1'b1;
                end
            end
            if (dcache_req_valid === 1'b1) begin
                checks++; if (pend == 0 || dcache_req_address !== stq[model_head].address || dcache_req_data !== stq[model_head].data) begin errors++; $display("FAIL rnd_payload cyc %0d: got a=%h d=%h pend=%0d expected a=%h d=%h", cyc, dcache_req_address, dcache_req_data, pend, stq[model_head].address, stq[model_head].data); end
            end
            hs = (dcache_req_valid === 1'b1) && dcache_req_ready;
            checks++; if (stq_dealloc !== hs) begin errors++; $display("FAIL rnd_dealloc cyc %0d: got %b expected %b", cyc, stq_dealloc, hs); end
            if (hs) begin
                stq[model_head] = '{valid: 1'b1, address: $urandom, data: $urandom};
                model_head = (model_head + 1) % STQ_SIZE;
                retired++;
                pend--;
                exp_flush = 1'b0;
            end
            if (rob_commit_store) begin
                committed++;
                pend++;
            end
            prev_fail = nxt_fail;
            prev_ok = nxt_ok;
            tick();
        end
        rob_commit_store = 1'b0;
        flush_ack = 1'b0;
        order_failures = '0;
        checks++; if (pend != 0 || retired != committed) begin errors++; $display("FAIL rnd_drain: got retired=%0d pend=%0d expected retired=%0d pend=0", retired, pend, committed); end
        @(negedge clk);
        checks++; if (dcache_req_valid !== 1'b0 || stq_head !== SW'(model_head)) begin errors++; $display("FAIL rnd_final: got v=%b head=%0d expected v=0 head=%0d", dcache_req_valid, stq_head, model_head); end
        tick();
    endtask

    initial begin
        reset_n = 1'b0;
        rob_commit_store = 1'b0;
        ldq_head = '0;
        order_failures = '0;
        dcache_req_ready = 1'b0;
        flush_ack = 1'b0;
        for (int i = 0; i < STQ_SIZE; i++) stq[i] = '{valid: 1'b1, address: $urandom, data: $urandom};
        test_reset();
        test_single_commit();
        test_backpressure();
        test_order_failure();
        test_burst_wrap();
        test_commit_during_dealloc();
        test_reset_mid_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
